// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
// Forwarding-select codes, FSM state type and the R15 (PC) register number.
package cpu_pipe_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    // R15 reads come from the PC path, so they never forward or stall.
    function automatic logic src_hit(input logic uses, input logic [3:0] src,
                                     input logic [3:0] rd);
        return uses && (src != REG_PC) && (src == rd);
    endfunction

    function automatic logic [1:0] fwd_pick(
        input logic       uses,
        input logic [3:0] src,
        input logic [3:0] ex_rd,
        input logic       ex_en,
        input logic       ex_load,
        input logic [3:0] mem_rd,
        input logic       mem_en,
        input logic [3:0] wb_rd,
        input logic       wb_en
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src_hit(uses, src, ex_rd) && ex_en && !ex_load) begin
            sel = FWD_EX;
        end else if (src_hit(uses, src, mem_rd) && mem_en) begin
            sel = FWD_MEM;
        end else if (src_hit(uses, src, wb_rd) && wb_en) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Width-parameterised up counter that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use bubbles, branch flush,
// data-memory wait freeze with timeout, and stall/flush perf counters.
module pipeline_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             R,
    input  logic [3:0]       ID_Rn,
    input  logic [3:0]       ID_Rm,
    input  logic [3:0]       ID_Rd,
    input  logic             ID_uses_Rn,
    input  logic             ID_uses_Rm,
    input  logic             ID_uses_Rd,
    input  logic             ID_branch_taken,
    input  logic [3:0]       EX_Rd,
    input  logic [3:0]       MEM_Rd,
    input  logic [3:0]       WB_Rd,
    input  logic             EX_RF_enable,
    input  logic             MEM_RF_enable,
    input  logic             WB_RF_enable,
    input  logic             EX_load_instr,
    input  logic             MEM_EN_MEM,
    input  logic             mem_ready,
    output logic [1:0]       fwd_Rn_sel,
    output logic [1:0]       fwd_Rm_sel,
    output logic [1:0]       fwd_Rd_sel,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             IF_ID_flush,
    output logic             ID_EX_nop,
    output logic             pipe_freeze,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_error_q, mem_error_d;
    logic                load_use;
    logic                mem_stall;
    logic [WAIT_W-1:0]   wait_next;

    assign mem_stall = MEM_EN_MEM && !mem_ready;
    assign load_use  = EX_load_instr && EX_RF_enable &&
                       (src_hit(ID_uses_Rn, ID_Rn, EX_Rd) ||
                        src_hit(ID_uses_Rm, ID_Rm, EX_Rd) ||
                        src_hit(ID_uses_Rd, ID_Rd, EX_Rd));

    // Freeze follows the live wait condition so the entry cycle already holds
    // the pipe; the state only tracks how long the wait has lasted.
    always_comb begin
        fwd_Rn_sel  = fwd_pick(ID_uses_Rn, ID_Rn, EX_Rd, EX_RF_enable, EX_load_instr,
                               MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable);
        fwd_Rm_sel  = fwd_pick(ID_uses_Rm, ID_Rm, EX_Rd, EX_RF_enable, EX_load_instr,
                               MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable);
        fwd_Rd_sel  = fwd_pick(ID_uses_Rd, ID_Rd, EX_Rd, EX_RF_enable, EX_load_instr,
                               MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable);
        PC_LE       = 1'b1;
        IF_ID_LE    = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_nop   = 1'b0;
        pipe_freeze = 1'b0;
        if (!R) begin
            fwd_Rn_sel  = FWD_RF;
            fwd_Rm_sel  = FWD_RF;
            fwd_Rd_sel  = FWD_RF;
            PC_LE       = 1'b0;
            IF_ID_LE    = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_nop   = 1'b1;
        end else if (mem_stall) begin
            pipe_freeze = 1'b1;
            PC_LE       = 1'b0;
            IF_ID_LE    = 1'b0;
        end else if (load_use) begin
            PC_LE       = 1'b0;
            IF_ID_LE    = 1'b0;
            ID_EX_nop   = 1'b1;
        end else if (ID_branch_taken) begin
            IF_ID_flush = 1'b1;
        end
    end

    always_comb begin
        state_d     = RUN;
        wait_cnt_d  = '0;
        mem_error_d = mem_error_q;
        wait_next   = ((state_q == MEM_WAIT) ? wait_cnt_q : '0) + WAIT_W'(1);
        if (mem_stall) begin
            if (int'(wait_next) >= MEM_TIMEOUT) begin
                mem_error_d = 1'b1;
            end else begin
                state_d    = MEM_WAIT;
                wait_cnt_d = wait_next;
            end
        end else if (load_use) begin
            state_d = LOAD_STALL;
        end
    end

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    assign mem_error = mem_error_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (R),
        .inc   (!PC_LE),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .rst_n (R),
        .inc   (IF_ID_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam int TMO   = 15;

    logic             Clk = 1'b0;
    logic             R;
    logic [3:0]       ID_Rn, ID_Rm, ID_Rd;
    logic             ID_uses_Rn, ID_uses_Rm, ID_uses_Rd;
    logic             ID_branch_taken;
    logic [3:0]       EX_Rd, MEM_Rd, WB_Rd;
    logic             EX_RF_enable, MEM_RF_enable, WB_RF_enable;
    logic             EX_load_instr, MEM_EN_MEM, mem_ready;
    logic [1:0]       fwd_Rn_sel, fwd_Rm_sel, fwd_Rd_sel;
    logic             PC_LE, IF_ID_LE, IF_ID_flush, ID_EX_nop, pipe_freeze, mem_error;
    logic [CNT_W-1:0] stall_count, flush_count;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .Clk(Clk), .R(R),
        .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
        .ID_uses_Rn(ID_uses_Rn), .ID_uses_Rm(ID_uses_Rm), .ID_uses_Rd(ID_uses_Rd),
        .ID_branch_taken(ID_branch_taken),
        .EX_Rd(EX_Rd), .MEM_Rd(MEM_Rd), .WB_Rd(WB_Rd),
        .EX_RF_enable(EX_RF_enable), .MEM_RF_enable(MEM_RF_enable), .WB_RF_enable(WB_RF_enable),
        .EX_load_instr(EX_load_instr), .MEM_EN_MEM(MEM_EN_MEM), .mem_ready(mem_ready),
        .fwd_Rn_sel(fwd_Rn_sel), .fwd_Rm_sel(fwd_Rm_sel), .fwd_Rd_sel(fwd_Rd_sel),
        .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_flush(IF_ID_flush),
        .ID_EX_nop(ID_EX_nop), .pipe_freeze(pipe_freeze), .mem_error(mem_error),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: counts kept as plain integers.
    int m_stall, m_flush, m_wait_cycles;
    bit m_err;
    logic [1:0] e_fwd [3];
    logic e_pc, e_ifid, e_flush, e_nop, e_freeze;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_wait_cycles = 0; m_err = 1'b0;
    endtask

    task automatic model_comb();
        logic [3:0] src [3];
        logic       use_ [3];
        logic [3:0] rd [3];
        logic       wen [3];
        bit hazard, found;
        src[0] = ID_Rn; src[1] = ID_Rm; src[2] = ID_Rd;
        use_[0] = ID_uses_Rn; use_[1] = ID_uses_Rm; use_[2] = ID_uses_Rd;
        rd[0] = EX_Rd;  wen[0] = EX_RF_enable && !EX_load_instr;
        rd[1] = MEM_Rd; wen[1] = MEM_RF_enable;
        rd[2] = WB_Rd;  wen[2] = WB_RF_enable;
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e_fwd[i] = 2'b00;
            if (use_[i] && src[i] != 4'd15) begin
                if (EX_load_instr && EX_RF_enable && EX_Rd == src[i]) hazard = 1'b1;
                found = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    if (!found && wen[s] && rd[s] == src[i]) begin
                        e_fwd[i] = 2'(s + 1);
                        found = 1'b1;
                    end
                end
            end
        end
        {e_pc, e_ifid, e_flush, e_nop, e_freeze} = 5'b11000;
        if (!R) begin
            for (int i = 0; i < 3; i++) e_fwd[i] = 2'b00;
            {e_pc, e_ifid, e_flush, e_nop, e_freeze} = 5'b00110;
        end else if (MEM_EN_MEM && !mem_ready) begin
            {e_pc, e_ifid, e_freeze} = 3'b001;
        end else if (hazard) begin
            {e_pc, e_ifid, e_nop} = 3'b001;
        end else if (ID_branch_taken) begin
            e_flush = 1'b1;
        end
    endtask

    task automatic model_edge();
        if (!e_pc && m_stall < (2 ** CNT_W) - 1) m_stall++;
        if (e_flush && m_flush < (2 ** CNT_W) - 1) m_flush++;
        if (MEM_EN_MEM && !mem_ready) begin
            m_wait_cycles++;
            if (m_wait_cycles >= TMO) begin
                m_err = 1'b1;
                m_wait_cycles = 0;
            end
        end else begin
            m_wait_cycles = 0;
        end
    endtask

    task automatic check_comb(input string tag);
        check({tag, ".fwd_rn"}, 32'(fwd_Rn_sel), 32'(e_fwd[0]));
        check({tag, ".fwd_rm"}, 32'(fwd_Rm_sel), 32'(e_fwd[1]));
        check({tag, ".fwd_rd"}, 32'(fwd_Rd_sel), 32'(e_fwd[2]));
        check({tag, ".pc_le"}, 32'(PC_LE), 32'(e_pc));
        check({tag, ".if_id_le"}, 32'(IF_ID_LE), 32'(e_ifid));
        check({tag, ".flush"}, 32'(IF_ID_flush), 32'(e_flush));
        check({tag, ".nop"}, 32'(ID_EX_nop), 32'(e_nop));
        check({tag, ".freeze"}, 32'(pipe_freeze), 32'(e_freeze));
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".stall_cnt"}, 32'(stall_count), 32'(m_stall));
        check({tag, ".flush_cnt"}, 32'(flush_count), 32'(m_flush));
        check({tag, ".mem_error"}, 32'(mem_error), 32'(m_err));
    endtask

    // Inputs are already driven; checks the cycle, clocks it, checks state.
    task automatic cycle(input string tag);
        #1;
        model_comb();
        check_comb(tag);
        @(posedge Clk);
        model_edge();
        #1;
        check_regs(tag);
    endtask

    task automatic drive_idle();
        ID_Rn = 4'd0; ID_Rm = 4'd0; ID_Rd = 4'd0;
        ID_uses_Rn = 1'b0; ID_uses_Rm = 1'b0; ID_uses_Rd = 1'b0;
        ID_branch_taken = 1'b0;
        EX_Rd = 4'd0; MEM_Rd = 4'd0; WB_Rd = 4'd0;
        EX_RF_enable = 1'b0; MEM_RF_enable = 1'b0; WB_RF_enable = 1'b0;
        EX_load_instr = 1'b0; MEM_EN_MEM = 1'b0; mem_ready = 1'b1;
    endtask

    function automatic logic [3:0] rreg();
        if ($urandom_range(0, 7) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        R = 1'b0;
        drive_idle();
        model_reset();
        #1;
        model_comb();
        check_comb("reset");
        @(posedge Clk); @(posedge Clk); #1;
        check_regs("reset");
        R = 1'b1;

        // EX forwarding and its priority over MEM/WB
        drive_idle();
        ID_Rn = 4'd1; ID_uses_Rn = 1'b1; EX_Rd = 4'd1; EX_RF_enable = 1'b1;
        cycle("fwd_ex");
        check("fwd_ex.const", 32'(fwd_Rn_sel), 32'd1);
        MEM_Rd = 4'd1; MEM_RF_enable = 1'b1; WB_Rd = 4'd1; WB_RF_enable = 1'b1;
        cycle("fwd_prio");
        check("fwd_prio.const", 32'(fwd_Rn_sel), 32'd1);

        // Load-use: one bubble, then the load forwards from MEM
        drive_idle();
        EX_Rd = 4'd2; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
        ID_Rm = 4'd2; ID_uses_Rm = 1'b1;
        cycle("load_use");
        check("load_use.stall_const", 32'(stall_count), 32'd1);
        EX_RF_enable = 1'b0; EX_load_instr = 1'b0; EX_Rd = 4'd0;
        MEM_Rd = 4'd2; MEM_RF_enable = 1'b1;
        cycle("load_mem");
        check("load_mem.fwd_const", 32'(fwd_Rm_sel), 32'd2);

        // Branch flush, then branch masked by a load-use hazard
        drive_idle();
        ID_branch_taken = 1'b1;
        cycle("branch");
        check("branch.flush_const", 32'(flush_count), 32'd1);
        EX_Rd = 4'd3; EX_RF_enable = 1'b1; EX_load_instr = 1'b1;
        ID_Rn = 4'd3; ID_uses_Rn = 1'b1;
        cycle("branch_haz");

        // Three-cycle memory wait
        drive_idle();
        MEM_EN_MEM = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mem_wait");
        mem_ready = 1'b1;
        cycle("mem_done");
        check("mem_done.stall_const", 32'(stall_count), 32'd5);

        // R15 never forwards
        drive_idle();
        ID_Rn = 4'd15; ID_uses_Rn = 1'b1; ID_Rd = 4'd15; ID_uses_Rd = 1'b1;
        WB_Rd = 4'd15; WB_RF_enable = 1'b1; MEM_Rd = 4'd15; MEM_RF_enable = 1'b1;
        cycle("r15");

        // Timeout after MEM_TIMEOUT wait cycles
        drive_idle();
        MEM_EN_MEM = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle("timeout");
            if (i == TMO - 2) check("timeout.before", 32'(mem_error), 32'd0);
            if (i == TMO - 1) check("timeout.at", 32'(mem_error), 32'd1);
        end
        mem_ready = 1'b1;
        cycle("timeout_done");

        // Reset asserted in the middle of a wait
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle("pre_reset");
        R = 1'b0;
        #1;
        model_reset();
        model_comb();
        check_comb("async_reset");
        check_regs("async_reset");
        @(posedge Clk); #1;
        R = 1'b1;
        drive_idle();
        cycle("post_reset");
        MEM_EN_MEM = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) cycle("post_reset_wait");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ID_Rn = rreg(); ID_Rm = rreg(); ID_Rd = rreg();
            ID_uses_Rn = 1'($urandom_range(0, 1));
            ID_uses_Rm = 1'($urandom_range(0, 1));
            ID_uses_Rd = 1'($urandom_range(0, 1));
            ID_branch_taken = ($urandom_range(0, 3) == 0);
            EX_Rd = rreg(); MEM_Rd = rreg(); WB_Rd = rreg();
            EX_RF_enable = 1'($urandom_range(0, 1));
            MEM_RF_enable = 1'($urandom_range(0, 1));
            WB_RF_enable = 1'($urandom_range(0, 1));
            EX_load_instr = ($urandom_range(0, 2) == 0);
            MEM_EN_MEM = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
